// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first through one
// full adder, one bit per clock, and presents a registered sum with carry out.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               c_q, c_d;
    logic               cout_q, cout_d;
    logic               last_bit;

    // Returns {carry, sum} of a single half adder.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    logic [1:0] ha0, ha1;
    logic       fa_s, fa_c;

    // The single full adder: two half-adder stages joined by an OR on the carries.
    always_comb begin
        ha0  = half_add(a_q[0], b_q[0]);
        ha1  = half_add(ha0[0], c_q);
        fa_s = ha1[0];
        fa_c = ha0[1] | ha1[1];
    end

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Operand and partial-result shifters carry no control meaning, so they are not reset.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        res_q <= res_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        res_d  = res_q;
        c_d    = c_q;
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    c_d   = 1'b0;
                    cnt_d = '0;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {fa_s, res_q[WIDTH-1:1]};
                c_d   = fa_c;
                cnt_d = cnt_q + CNT_W'(1);
                // Publish only the finished word so sum never shows partial bits.
                if (last_bit) begin
                    sum_d  = {fa_s, res_q[WIDTH-1:1]};
                    cout_d = fa_c;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl (WIDTH=8) against a plain
// arithmetic model of accept timing, latency and the a+b result.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;

    int tests_run;
    int failures;

    logic [W-1:0] model_sum;
    logic         model_cout;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        step();
        start = 1'b1;
        a = 8'hFF;
        b = 8'h01;
        step();
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: busy=%b done=%b expected 0 0", busy, done);
        end
        tests_run++;
        if (sum !== 8'h00 || carry_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: sum=%h cout=%b expected 00 0", sum, carry_out);
        end
        model_sum  = '0;
        model_cout = 1'b0;
    endtask

    // mode 0: plain; mode 1: start re-asserted at SHIFT cycle 3; mode 2: operands zeroed after accept
    task automatic run_add(input logic [W-1:0] av, input logic [W-1:0] bv, input int mode,
                           input string name);
        logic [W:0] exp;
        int         dones;
        exp   = {1'b0, av} + {1'b0, bv};
        dones = 0;
        a     = av;
        b     = bv;
        start = 1'b1;
        step();
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s accept: busy=%b expected 1", name, busy);
        end
        if (mode == 2) begin
            a = 8'h00;
            b = 8'h00;
        end
        for (int k = 1; k <= 12; k++) begin
            if (mode == 1 && k == 3) begin
                start = 1'b1;
                a     = ~av;
                b     = 8'h33;
            end
            step();
            start = 1'b0;
            tests_run++;
            if (busy !== 1'(k < W)) begin
                failures++;
                $display("FAIL %s busy@%0d: got %b expected %b", name, k, busy, 1'(k < W));
            end
            tests_run++;
            if (done !== 1'(k == W)) begin
                failures++;
                $display("FAIL %s done@%0d: got %b expected %b", name, k, done, 1'(k == W));
            end
            if (done) dones++;
            if (k < W) begin
                tests_run++;
                if (sum !== model_sum || carry_out !== model_cout) begin
                    failures++;
                    $display("FAIL %s hold@%0d: sum=%h cout=%b expected %h %b",
                             name, k, sum, carry_out, model_sum, model_cout);
                end
            end else begin
                tests_run++;
                if (sum !== exp[W-1:0] || carry_out !== exp[W]) begin
                    failures++;
                    $display("FAIL %s result@%0d: sum=%h cout=%b expected %h %b",
                             name, k, sum, carry_out, exp[W-1:0], exp[W]);
                end
            end
        end
        tests_run++;
        if (dones != 1) begin
            failures++;
            $display("FAIL %s done_count: got %0d expected 1", name, dones);
        end
        model_sum  = exp[W-1:0];
        model_cout = exp[W];
    endtask

    task automatic test_idle_hold();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a = W'($urandom);
            b = W'($urandom);
            step();
            tests_run++;
            if (busy !== 1'b0 || done !== 1'b0 || sum !== model_sum || carry_out !== model_cout) begin
                failures++;
                $display("FAIL idle_hold@%0d: busy=%b done=%b sum=%h cout=%b expected 0 0 %h %b",
                         k, busy, done, sum, carry_out, model_sum, model_cout);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        int dones;
        dones = 0;
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carry_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_shift: busy=%b done=%b sum=%h cout=%b expected 0 0 00 0",
                     busy, done, sum, carry_out);
        end
        for (int k = 0; k < 12; k++) begin
            step();
            if (done) dones++;
        end
        tests_run++;
        if (dones != 0 || sum !== 8'h00) begin
            failures++;
            $display("FAIL reset_no_done: dones=%0d sum=%h expected 0 00", dones, sum);
        end
        model_sum  = '0;
        model_cout = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ops_a[$];
        logic [W-1:0] ops_b[$];
        logic [W:0]   exp;
        int           next_accept;
        int           pulses;
        next_accept = 0;
        pulses      = 0;
        for (int j = 0; j < 32; j++) begin
            start = 1'(j < 20);
            a     = W'($urandom);
            b     = W'($urandom);
            // Model: from IDLE with start held, accepts repeat every W+2 edges.
            if (j < 20 && j == next_accept) begin
                ops_a.push_back(a);
                ops_b.push_back(b);
                next_accept = j + W + 2;
            end
            step();
            tests_run++;
            if (busy !== 1'(j < 20 && (j % (W + 2)) < W)) begin
                failures++;
                $display("FAIL b2b busy@%0d: got %b", j, busy);
            end
            tests_run++;
            if (done !== 1'(j < 20 && (j % (W + 2)) == W)) begin
                failures++;
                $display("FAIL b2b done@%0d: got %b", j, done);
            end
            if (done && ops_a.size() > 0) begin
                exp = {1'b0, ops_a.pop_front()} + {1'b0, ops_b.pop_front()};
                pulses++;
                tests_run++;
                if (sum !== exp[W-1:0] || carry_out !== exp[W]) begin
                    failures++;
                    $display("FAIL b2b result@%0d: sum=%h cout=%b expected %h %b",
                             j, sum, carry_out, exp[W-1:0], exp[W]);
                end
                model_sum  = exp[W-1:0];
                model_cout = exp[W];
            end
        end
        start = 1'b0;
        tests_run++;
        if (pulses != 2) begin
            failures++;
            $display("FAIL b2b pulses: got %0d expected 2", pulses);
        end
    endtask

    initial begin
        tests_run  = 0;
        failures   = 0;
        model_sum  = '0;
        model_cout = 1'b0;
        rst_n      = 1'b0;
        start      = 1'b0;
        a          = '0;
        b          = '0;

        test_reset();
        rst_n = 1'b1;
        run_add(8'h00, 8'h00, 0, "zero_first_edge");
        run_add(8'hFF, 8'h01, 0, "wrap_ff_01");
        run_add(8'hA5, 8'h5A, 0, "a5_5a");
        test_idle_hold();
        run_add(8'h3C, 8'h47, 1, "restart_ignored");
        run_add(8'h80, 8'h80, 2, "operand_change");
        for (int i = 0; i < 6; i++) begin
            run_add(W'($urandom), W'($urandom), 0, "random");
        end
        test_reset_mid_shift();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
